if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
//  - Owns the PC register.
//  - Issues one instruction-memory request at a time over a req/ready + rvalid handshake.
//  - Captures the returned word and presents {pc, pc+4, instruction, valid} to IF/ID.
//  - Handles hazard-unit stalls and EX-stage redirects (taken branch/jump), discarding stale responses.
// PARAMETERS
//  data_width     32   instruction width
//  address_width  12   byte-address/PC width; all PC arithmetic is modulo 2^address_width
//  RESET_PC       0    PC value loaded on reset (address_width bits)
// PORTS
//  clk            in   1    single clock, rising edge
//  reset          in   1    asynchronous, active-low reset (0 = reset)
//  stall          in   1    from hazard unit: IF/ID not accepting this cycle
//  redirect       in   1    from EX: taken branch/jump this cycle
//  redirect_pc    in   aw   target PC for redirect
//  imem_req       out  1    request valid; address on imem_addr
//  imem_addr      out  aw   fetch address (= PC register)
//  imem_ready     in   1    memory accepts request this cycle (req && ready = accept)
//  imem_rvalid    in   1    read data valid (exactly one per accepted request, >=1 cycle later)
//  imem_rdata     in   dw   instruction word
//  IF_pc_current  out  aw   PC of presented instruction
//  IF_pc_plus_4   out  aw   IF_pc_current + 4 (wraps)
//  IF_instruction out  dw   presented instruction; 32'h00000013 (NOP) whenever IF_valid=0
//  IF_valid       out  1    presented instruction is real; IF/ID consumes it when IF_valid && !stall
// BEHAVIOUR
//  States: IDLE, REQ, WAIT, HOLD, DROP. At most one request outstanding.
//  Reset (async, reset=0):
//   - state=IDLE, pc=RESET_PC, imem_req=0, IF_valid=0
//   - IF_instruction=NOP, IF_pc_current=0, IF_pc_plus_4=0
//   - Reset mid-transaction abandons it; an rvalid arriving after reset release while in IDLE/REQ is ignored.
//  IDLE: -> REQ next cycle unconditionally.
//  REQ: imem_req=1, imem_addr=pc.
//   - Accept (imem_ready=1) -> WAIT; if redirect in the same cycle: pc<=redirect_pc, -> DROP.
//   - No accept + redirect: pc<=redirect_pc, stay REQ (address may change while unaccepted).
//  WAIT: imem_req=0.
//   - rvalid, no redirect: capture rdata and pc into output regs, IF_valid<=1, -> HOLD.
//   - rvalid + redirect: discard data, pc<=redirect_pc, -> REQ.
//   - Redirect without rvalid: pc<=redirect_pc, -> DROP.
//  DROP: wait for rvalid, discard it (outputs unchanged, IF_valid stays 0), -> REQ.
//   - Further redirects in DROP only update pc.
//  HOLD: outputs stable, IF_valid=1.
//   - !stall && !redirect: consumed this cycle; pc<=pc+4, IF_valid<=0, -> REQ.
//   - stall && !redirect: hold all outputs.
//   - redirect (any stall value): IF_valid<=0, pc<=redirect_pc, -> REQ. Redirect always beats stall.
//  Outputs are registered. IF_pc_plus_4 is computed from the captured PC.
//  When IF_valid=0, IF_instruction is forced to NOP so IF/ID latches a bubble.
//  Timing with zero-wait memory (ready=1, rvalid 1 cycle after accept):
//   - Accept cycle N, rvalid N+1, IF_valid=1 at N+2; next request at N+3 if not stalled.
//  Wrap: pc = 2^aw-4 advances to 0; IF_pc_plus_4 = 0 for that instruction.
//  rvalid with no request outstanding (IDLE/REQ/HOLD) is ignored.
// TESTING
//  1. Reset: hold reset=0 for 3 cycles, then release; ready=1, rvalid 1 cycle after accept
//     -> imem_addr 0,4,8; IF_valid pulses each 3 cycles; IF_pc_plus_4 = pc+4.
//  2. Stall: assert stall for 4 cycles while in HOLD with pc=8 -> outputs frozen at pc 8 and
//     its instruction; imem_req=0; after release, next request addr=12.
//  3. Memory latency: rvalid 5 cycles after accept
//     -> IF_valid=0 and IF_instruction=0x00000013 throughout; captures correct word on rvalid.
//  4. Redirect in WAIT: redirect_pc=0x100 in WAIT, stale rvalid 2 cycles later
//     -> stale word never shown; next request addr=0x100.
//  5. Redirect during HOLD with stall=1 -> IF_valid drops next cycle; request at redirect_pc.
//     Also redirect coinciding with accept -> DROP path taken.
//  6. Wrap and async reset: RESET_PC=0xFFC gives IF_pc_plus_4=0, next addr 0;
//     asserting reset mid-WAIT clears all outputs immediately, without a clock edge.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// presents {pc, pc+4, instruction, valid} to the IF/ID register.
module if_fetch_unit #(
   parameter int unsigned               data_width    = 32,
   parameter int unsigned               address_width = 12,
   parameter logic [address_width-1:0]  RESET_PC      = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     redirect,
   input  logic [address_width-1:0] redirect_pc,
   output logic                     imem_req,
   output logic [address_width-1:0] imem_addr,
   input  logic                     imem_ready,
   input  logic                     imem_rvalid,
   input  logic [data_width-1:0]    imem_rdata,
   output logic [address_width-1:0] IF_pc_current,
   output logic [address_width-1:0] IF_pc_plus_4,
   output logic [data_width-1:0]    IF_instruction,
   output logic                     IF_valid
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] REQ  = 3'd1;
   localparam logic [2:0] WAIT = 3'd2;
   localparam logic [2:0] HOLD = 3'd3;
   localparam logic [2:0] DROP = 3'd4;

   localparam logic [data_width-1:0] NOP = data_width'(32'h0000_0013);

   logic [2:0]               state;
   logic [address_width-1:0] pc;
   logic [address_width-1:0] pc_seq;

   assign pc_seq    = pc + address_width'(4);
   assign imem_req  = (state == REQ);
   assign imem_addr = pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         IF_valid       <= 1'b0;
         IF_instruction <= NOP;
         IF_pc_current  <= '0;
         IF_pc_plus_4   <= '0;
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               // An unaccepted request may retarget; an accepted one becomes stale.
               if (redirect)
                  pc <= redirect_pc;
               if (imem_ready)
                  state <= redirect ? DROP : WAIT;
            end
            WAIT: begin
               if (redirect) begin
                  pc    <= redirect_pc;
                  state <= imem_rvalid ? REQ : DROP;
               end else if (imem_rvalid) begin
                  IF_instruction <= imem_rdata;
                  IF_pc_current  <= pc;
                  IF_pc_plus_4   <= pc_seq;
                  IF_valid       <= 1'b1;
                  state          <= HOLD;
               end
            end
            DROP: begin
               if (redirect)
                  pc <= redirect_pc;
               if (imem_rvalid)
                  state <= REQ;
            end
            HOLD: begin
               // Redirect wins over stall; a consumed word advances sequentially.
               if (redirect || !stall) begin
                  IF_valid       <= 1'b0;
                  IF_instruction <= NOP;
                  pc             <= redirect ? redirect_pc : pc_seq;
                  state          <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit with a latency-programmable
// instruction memory responder and a second instance for PC wrap / async reset.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, stall, redirect, imem_ready, imem_rvalid;
   logic [11:0] redirect_pc, imem_addr, IF_pc_current, IF_pc_plus_4;
   logic [31:0] imem_rdata, IF_instruction;
   logic        imem_req, IF_valid;

   logic        w_reset, w_stall, w_redirect, w_ready, w_rvalid;
   logic [11:0] w_redirect_pc, w_addr, w_pc, w_pc4;
   logic [31:0] w_rdata, w_instr;
   logic        w_req, w_valid;

   if_fetch_unit #(.data_width(32), .address_width(12), .RESET_PC(12'h000)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .IF_pc_current(IF_pc_current), .IF_pc_plus_4(IF_pc_plus_4),
      .IF_instruction(IF_instruction), .IF_valid(IF_valid)
   );

   if_fetch_unit #(.data_width(32), .address_width(12), .RESET_PC(12'hFFC)) dut_wrap (
      .clk(clk), .reset(w_reset), .stall(w_stall), .redirect(w_redirect),
      .redirect_pc(w_redirect_pc), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ready(w_ready), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .IF_pc_current(w_pc), .IF_pc_plus_4(w_pc4),
      .IF_instruction(w_instr), .IF_valid(w_valid)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          lat;
      logic        ready, stall, redir;
      logic [11:0] rpc;
      logic        e_req;
      logic [11:0] e_addr;
      logic        e_valid;
      logic [11:0] e_pc;
   } vec_t;

   vec_t vq[$];

   int          lat = 1;
   bit          pend = 1'b0;
   int          cd = 0;
   logic [11:0] paddr = '0;

   function automatic vec_t mk(int l, logic rdy, logic st, logic rd, logic [11:0] rpc,
                               logic req, logic [11:0] addr, logic vld, logic [11:0] pc);
      vec_t v;
      v.lat = l; v.ready = rdy; v.stall = st; v.redir = rd; v.rpc = rpc;
      v.e_req = req; v.e_addr = addr; v.e_valid = vld; v.e_pc = pc;
      return v;
   endfunction

   function automatic logic [31:0] mem_word(logic [11:0] a);
      return 32'hA000_0000 | {20'h0, a};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: rvalid arrives exactly lat cycles after the accept cycle.
   task automatic tick();
      logic        acc;
      logic [11:0] a;
      acc = imem_req && imem_ready;
      a   = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (acc) begin
         pend = 1'b1; cd = lat; paddr = a;
      end
      if (pend) begin
         cd--;
         if (cd == 0) begin
            pend        = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      w_reset = 1'b1; w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;
      w_ready = 1'b1; w_rvalid = 1'b0; w_rdata = '0;

      //         lat rdy st rd rpc      req addr     vld pc
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c0 IDLE
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 1, 12'h000, 0, 12'h000)); // c1
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c2
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h000)); // c3
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 1, 12'h004, 0, 12'h000)); // c4
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c5
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h004)); // c6
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 1, 12'h008, 0, 12'h000)); // c7
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c8
      vq.push_back(mk(1, 1, 1, 0, 12'h000, 0, 12'h000, 1, 12'h008)); // c9  stall
      vq.push_back(mk(1, 1, 1, 0, 12'h000, 0, 12'h000, 1, 12'h008)); // c10
      vq.push_back(mk(1, 1, 1, 0, 12'h000, 0, 12'h000, 1, 12'h008)); // c11
      vq.push_back(mk(1, 1, 1, 0, 12'h000, 0, 12'h000, 1, 12'h008)); // c12
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h008)); // c13 consumed
      vq.push_back(mk(5, 1, 0, 0, 12'h000, 1, 12'h00C, 0, 12'h000)); // c14 accept, lat 5
      vq.push_back(mk(5, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c15
      vq.push_back(mk(5, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c16
      vq.push_back(mk(5, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c17
      vq.push_back(mk(5, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c18
      vq.push_back(mk(5, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c19 rvalid
      vq.push_back(mk(5, 1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h00C)); // c20
      vq.push_back(mk(3, 1, 0, 0, 12'h000, 1, 12'h010, 0, 12'h000)); // c21 accept, lat 3
      vq.push_back(mk(3, 1, 0, 1, 12'h100, 0, 12'h000, 0, 12'h000)); // c22 redirect in WAIT
      vq.push_back(mk(3, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c23 DROP
      vq.push_back(mk(3, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c24 stale rvalid
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 1, 12'h100, 0, 12'h000)); // c25
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c26
      vq.push_back(mk(1, 1, 1, 1, 12'h200, 0, 12'h000, 1, 12'h100)); // c27 redirect+stall in HOLD
      vq.push_back(mk(1, 1, 0, 1, 12'h300, 1, 12'h200, 0, 12'h000)); // c28 redirect+accept
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c29 DROP, rvalid
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 1, 12'h300, 0, 12'h000)); // c30
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c31
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h300)); // c32
      vq.push_back(mk(1, 0, 0, 1, 12'h400, 1, 12'h304, 0, 12'h000)); // c33 redirect, no accept
      vq.push_back(mk(1, 0, 0, 0, 12'h000, 1, 12'h400, 0, 12'h000)); // c34
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 1, 12'h400, 0, 12'h000)); // c35
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000)); // c36
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h400)); // c37
      vq.push_back(mk(1, 1, 0, 0, 12'h000, 1, 12'h404, 0, 12'h000)); // c38

      #2;
      reset = 1'b0; w_reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'h0, IF_valid}, 32'h0);
      chk("rst_instr", IF_instruction, NOP);
      chk("rst_pc",    {20'h0, IF_pc_current}, 32'h0);
      chk("rst_pc4",   {20'h0, IF_pc_plus_4}, 32'h0);
      chk("rst_req",   {31'h0, imem_req}, 32'h0);
      chk("rst_addr",  {20'h0, imem_addr}, 32'h0);
      reset = 1'b1;

      foreach (vq[i]) begin
         lat         = vq[i].lat;
         imem_ready  = vq[i].ready;
         stall       = vq[i].stall;
         redirect    = vq[i].redir;
         redirect_pc = vq[i].rpc;
         chk($sformatf("c%0d_req", i), {31'h0, imem_req}, {31'h0, vq[i].e_req});
         if (vq[i].e_req)
            chk($sformatf("c%0d_addr", i), {20'h0, imem_addr}, {20'h0, vq[i].e_addr});
         chk($sformatf("c%0d_valid", i), {31'h0, IF_valid}, {31'h0, vq[i].e_valid});
         if (vq[i].e_valid) begin
            chk($sformatf("c%0d_pc", i), {20'h0, IF_pc_current}, {20'h0, vq[i].e_pc});
            chk($sformatf("c%0d_pc4", i), {20'h0, IF_pc_plus_4},
                {20'h0, vq[i].e_pc + 12'd4});
            chk($sformatf("c%0d_instr", i), IF_instruction, mem_word(vq[i].e_pc));
         end else begin
            chk($sformatf("c%0d_instr", i), IF_instruction, NOP);
         end
         tick();
      end
      stall = 1'b0; redirect = 1'b0;

      // Wrap instance: RESET_PC=0xFFC, then async reset in the middle of WAIT.
      w_reset = 1'b1;
      chk("w_c0_req", {31'h0, w_req}, 32'h0);
      chk("w_c0_addr", {20'h0, w_addr}, 32'h0000_0FFC);
      cyc();
      chk("w_c1_req", {31'h0, w_req}, 32'h1);
      chk("w_c1_addr", {20'h0, w_addr}, 32'h0000_0FFC);
      cyc();
      w_rvalid = 1'b1; w_rdata = 32'hB000_0FFC;
      chk("w_c2_req", {31'h0, w_req}, 32'h0);
      cyc();
      w_rvalid = 1'b0;
      chk("w_c3_valid", {31'h0, w_valid}, 32'h1);
      chk("w_c3_pc", {20'h0, w_pc}, 32'h0000_0FFC);
      chk("w_c3_pc4", {20'h0, w_pc4}, 32'h0);
      chk("w_c3_instr", w_instr, 32'hB000_0FFC);
      cyc();
      chk("w_c4_req", {31'h0, w_req}, 32'h1);
      chk("w_c4_addr", {20'h0, w_addr}, 32'h0);
      cyc();
      chk("w_c5_req", {31'h0, w_req}, 32'h0);
      #1;
      w_reset = 1'b0;
      #1;
      chk("w_arst_valid", {31'h0, w_valid}, 32'h0);
      chk("w_arst_instr", w_instr, NOP);
      chk("w_arst_pc", {20'h0, w_pc}, 32'h0);
      chk("w_arst_pc4", {20'h0, w_pc4}, 32'h0);
      chk("w_arst_req", {31'h0, w_req}, 32'h0);
      chk("w_arst_addr", {20'h0, w_addr}, 32'h0000_0FFC);
      w_rvalid = 1'b1; w_rdata = 32'hDEAD_BEEF;
      cyc();
      w_reset = 1'b1;
      cyc();
      w_ready = 1'b0;
      chk("w_r1_req", {31'h0, w_req}, 32'h1);
      cyc();
      chk("w_r2_req", {31'h0, w_req}, 32'h1);
      chk("w_r2_addr", {20'h0, w_addr}, 32'h0000_0FFC);
      chk("w_r2_valid", {31'h0, w_valid}, 32'h0);
      chk("w_r2_instr", w_instr, NOP);
      w_rvalid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
